// File: rtl/branch_redirect_if.sv
// Shared PC-selector opcode type plus the decode/execute/fetch bundle for branch_redirect.
// Ports (via modports): fetch_ready, hazard_stall, id_valid, id_is_ctrl, id_pc,
// ex_valid, ex_kind, ex_taken, ex_pc, ex_imm, ex_rs1 (toward the sequencer);
// op, offset, stall_pc, flush_if, busy, br_cnt, taken_cnt (from the sequencer).
package branch_redirect_pkg;
    typedef enum logic [2:0] {
        PLUS4    = 3'd0,
        MAINTAIN = 3'd1,
        BEQ_P    = 3'd2,
        BEQ_N    = 3'd3,
        JAL_P    = 3'd4,
        JALR_P   = 3'd5
    } instfunc_t;

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_BEQ  = 2'd1;
    localparam logic [1:0] KIND_JAL  = 2'd2;
    localparam logic [1:0] KIND_JALR = 2'd3;
endpackage

interface branch_redirect_if #(
    parameter int unsigned CNT_W = 32
);
    import branch_redirect_pkg::*;

    logic             fetch_ready;
    logic             hazard_stall;
    logic             id_valid;
    logic             id_is_ctrl;
    logic [63:0]      id_pc;
    logic             ex_valid;
    logic [1:0]       ex_kind;
    logic             ex_taken;
    logic [63:0]      ex_pc;
    logic [63:0]      ex_imm;
    logic [63:0]      ex_rs1;
    instfunc_t        op;
    logic [63:0]      offset;
    logic [63:0]      stall_pc;
    logic             flush_if;
    logic             busy;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    // Pipeline side: drives decode/execute/fetch status, consumes the redirect.
    modport master (
        output fetch_ready, hazard_stall, id_valid, id_is_ctrl, id_pc,
               ex_valid, ex_kind, ex_taken, ex_pc, ex_imm, ex_rs1,
        input  op, offset, stall_pc, flush_if, busy, br_cnt, taken_cnt
    );

    // Sequencer side.
    modport slave (
        input  fetch_ready, hazard_stall, id_valid, id_is_ctrl, id_pc,
               ex_valid, ex_kind, ex_taken, ex_pc, ex_imm, ex_rs1,
        output op, offset, stall_pc, flush_if, busy, br_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_redirect.sv
// Fetch-side control-flow sequencer: freezes the PC on a decoded control transfer,
// waits for execute to resolve it, then holds the op/offset/stall_pc redirect until
// fetch accepts it. Keeps resolved / taken counters.
// Ports: clk, reset (async active-low), bus (branch_redirect_if.slave).
module branch_redirect
    import branch_redirect_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_redirect_if.slave       bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [63:0]      stall_pc_q, stall_pc_d;
    logic [63:0]      off_q, off_d;
    instfunc_t        op_q, op_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    instfunc_t        op_c;
    logic             flush_c;
    logic             is_taken;
    logic [63:0]      jalr_sum;

    // JALR target wraps modulo 2^64; bit 0 is cleared afterwards.
    assign jalr_sum = bus.ex_rs1 + bus.ex_imm;

    // State and redirect registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            stall_pc_q  <= 64'd0;
            off_q       <= 64'd0;
            op_q        <= PLUS4;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_pc_q  <= stall_pc_d;
            off_q       <= off_d;
            op_q        <= op_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Next-state, resolution and PC-selector opcode.
    always_comb begin
        state_d     = state_q;
        stall_pc_d  = stall_pc_q;
        off_d       = off_q;
        op_d        = op_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        op_c        = MAINTAIN;
        flush_c     = 1'b0;
        is_taken    = 1'b0;

        case (state_q)
            S_IDLE: begin
                op_c = (bus.hazard_stall || !bus.fetch_ready) ? MAINTAIN : PLUS4;
                // A decoded control transfer wins over a concurrent hazard stall.
                if (bus.id_valid && bus.id_is_ctrl) begin
                    stall_pc_d = bus.id_pc;
                    flush_c    = 1'b1;
                    op_c       = MAINTAIN;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.ex_valid && (bus.ex_pc == stall_pc_q)) begin
                    case (bus.ex_kind)
                        KIND_BEQ: begin
                            if (bus.ex_taken) begin
                                op_d     = BEQ_P;
                                off_d    = bus.ex_imm;
                                is_taken = 1'b1;
                            end else begin
                                op_d  = BEQ_N;
                                off_d = 64'd0;
                            end
                        end
                        KIND_JAL: begin
                            op_d     = JAL_P;
                            off_d    = bus.ex_imm;
                            is_taken = 1'b1;
                        end
                        KIND_JALR: begin
                            op_d     = JALR_P;
                            off_d    = jalr_sum & ~64'h1;
                            is_taken = 1'b1;
                        end
                        default: begin
                            // Kind "none" at the matching PC falls through as not-taken.
                            op_d  = BEQ_N;
                            off_d = 64'd0;
                        end
                    endcase
                    br_cnt_d = br_cnt_q + CNT_W'(1);
                    if (is_taken) begin
                        taken_cnt_d = taken_cnt_q + CNT_W'(1);
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                op_c = op_q;
                if (bus.fetch_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset forces a frozen PC and no flush without waiting for a clock edge.
    assign bus.op        = reset ? op_c : MAINTAIN;
    assign bus.flush_if  = reset & flush_c;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.offset    = off_q;
    assign bus.stall_pc  = stall_pc_q;
    assign bus.br_cnt    = br_cnt_q;
    assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed self-checking bench for branch_redirect.
module tb_branch_redirect;
    import branch_redirect_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    branch_redirect_if #(.CNT_W(32)) bus ();

    branch_redirect #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [1:0] kind, input logic tk,
                          input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rs1);
        bus.ex_valid = v;
        bus.ex_kind  = kind;
        bus.ex_taken = tk;
        bus.ex_pc    = pc;
        bus.ex_imm   = imm;
        bus.ex_rs1   = rs1;
    endtask

    task automatic id_set(input logic v, input logic [63:0] pc);
        bus.id_valid   = v;
        bus.id_is_ctrl = v;
        bus.id_pc      = pc;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.fetch_ready  = 1'b1;
        bus.hazard_stall = 1'b0;
        id_set(1'b0, 64'd0);
        ex_set(1'b0, KIND_NONE, 1'b0, 64'd0, 64'd0, 64'd0);

        // Reset state
        #2;
        chk("rst_op", 64'(bus.op), 64'(MAINTAIN));
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_flush", 64'(bus.flush_if), 64'd0);
        chk("rst_offset", bus.offset, 64'd0);
        chk("rst_brcnt", 64'(bus.br_cnt), 64'd0);
        step();
        reset = 1'b1;
        #1;
        chk("idle_op", 64'(bus.op), 64'(PLUS4));

        // BEQ taken, execute two cycles after detect
        id_set(1'b1, 64'h8000_0010);
        #1;
        chk("beq_t_flush", 64'(bus.flush_if), 64'd1);
        chk("beq_t_detect_op", 64'(bus.op), 64'(MAINTAIN));
        step();
        id_set(1'b0, 64'd0);
        #1;
        chk("beq_t_wait_flush", 64'(bus.flush_if), 64'd0);
        chk("beq_t_wait_op", 64'(bus.op), 64'(MAINTAIN));
        chk("beq_t_wait_busy", 64'(bus.busy), 64'd1);
        step();
        ex_set(1'b1, KIND_BEQ, 1'b1, 64'h8000_0010, 64'h20, 64'd0);
        #1;
        chk("beq_t_match_op", 64'(bus.op), 64'(MAINTAIN));
        step();
        ex_set(1'b0, KIND_NONE, 1'b0, 64'd0, 64'd0, 64'd0);
        #1;
        chk("beq_t_op", 64'(bus.op), 64'(BEQ_P));
        chk("beq_t_off", bus.offset, 64'h20);
        chk("beq_t_spc", bus.stall_pc, 64'h8000_0010);
        chk("beq_t_br", 64'(bus.br_cnt), 64'd1);
        chk("beq_t_tk", 64'(bus.taken_cnt), 64'd1);
        step();
        chk("beq_t_done_busy", 64'(bus.busy), 64'd0);
        chk("beq_t_done_op", 64'(bus.op), 64'(PLUS4));

        // BEQ not taken, execute right after detect
        id_set(1'b1, 64'h8000_0010);
        step();
        id_set(1'b0, 64'd0);
        ex_set(1'b1, KIND_BEQ, 1'b0, 64'h8000_0010, 64'h20, 64'd0);
        step();
        ex_set(1'b0, KIND_NONE, 1'b0, 64'd0, 64'd0, 64'd0);
        #1;
        chk("beq_n_op", 64'(bus.op), 64'(BEQ_N));
        chk("beq_n_off", bus.offset, 64'd0);
        chk("beq_n_br", 64'(bus.br_cnt), 64'd2);
        chk("beq_n_tk", 64'(bus.taken_cnt), 64'd1);
        step();

        // JALR with negative immediate, bit 0 cleared
        id_set(1'b1, 64'h8000_0040);
        step();
        id_set(1'b0, 64'd0);
        ex_set(1'b1, KIND_JALR, 1'b0, 64'h8000_0040, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_1003);
        step();
        ex_set(1'b0, KIND_NONE, 1'b0, 64'd0, 64'd0, 64'd0);
        #1;
        chk("jalr_op", 64'(bus.op), 64'(JALR_P));
        chk("jalr_off", bus.offset, 64'h8000_1000);
        chk("jalr_tk", 64'(bus.taken_cnt), 64'd2);
        step();

        // JAL under fetch backpressure; hazard ignored in ISSUE
        id_set(1'b1, 64'h8000_0080);
        step();
        id_set(1'b0, 64'd0);
        ex_set(1'b1, KIND_JAL, 1'b0, 64'h8000_0080, 64'h100, 64'd0);
        bus.fetch_ready = 1'b0;
        step();
        ex_set(1'b0, KIND_NONE, 1'b0, 64'd0, 64'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            bus.hazard_stall = (i == 2);
            #1;
            chk("bp_op", 64'(bus.op), 64'(JAL_P));
            chk("bp_off", bus.offset, 64'h100);
            chk("bp_br", 64'(bus.br_cnt), 64'd4);
            step();
        end
        bus.hazard_stall = 1'b0;
        bus.fetch_ready  = 1'b1;
        #1;
        chk("bp_last_op", 64'(bus.op), 64'(JAL_P));
        chk("bp_last_busy", 64'(bus.busy), 64'd1);
        step();
        chk("bp_done_busy", 64'(bus.busy), 64'd0);
        chk("bp_done_br", 64'(bus.br_cnt), 64'd4);
        chk("bp_done_tk", 64'(bus.taken_cnt), 64'd3);

        // Stall in IDLE, then mismatching / invalid execute in WAIT
        bus.hazard_stall = 1'b1;
        #1;
        chk("stall_op", 64'(bus.op), 64'(MAINTAIN));
        step();
        chk("stall_busy", 64'(bus.busy), 64'd0);
        bus.hazard_stall = 1'b0;
        bus.fetch_ready  = 1'b0;
        #1;
        chk("notready_op", 64'(bus.op), 64'(MAINTAIN));
        bus.fetch_ready  = 1'b1;
        bus.hazard_stall = 1'b1;
        id_set(1'b1, 64'h0000_1000);
        #1;
        chk("stall_capture_flush", 64'(bus.flush_if), 64'd1);
        step();
        bus.hazard_stall = 1'b0;
        ex_set(1'b1, KIND_BEQ, 1'b1, 64'h0000_1004, 64'h8, 64'd0);
        #1;
        chk("wait_ctrl_ignored", 64'(bus.flush_if), 64'd0);
        step();
        id_set(1'b0, 64'd0);
        ex_set(1'b0, KIND_BEQ, 1'b1, 64'h0000_1000, 64'h8, 64'd0);
        #1;
        chk("mismatch_busy", 64'(bus.busy), 64'd1);
        chk("mismatch_op", 64'(bus.op), 64'(MAINTAIN));
        step();
        chk("invalid_busy", 64'(bus.busy), 64'd1);
        chk("invalid_br", 64'(bus.br_cnt), 64'd4);
        ex_set(1'b1, KIND_NONE, 1'b1, 64'h0000_1000, 64'h8, 64'd0);
        step();
        ex_set(1'b0, KIND_NONE, 1'b0, 64'd0, 64'd0, 64'd0);
        #1;
        chk("kind0_op", 64'(bus.op), 64'(BEQ_N));
        chk("kind0_off", bus.offset, 64'd0);
        chk("kind0_tk", 64'(bus.taken_cnt), 64'd3);
        step();

        // Asynchronous reset while in ISSUE
        id_set(1'b1, 64'h8000_0100);
        step();
        id_set(1'b0, 64'd0);
        ex_set(1'b1, KIND_JAL, 1'b0, 64'h8000_0100, 64'h40, 64'd0);
        bus.fetch_ready = 1'b0;
        step();
        ex_set(1'b0, KIND_NONE, 1'b0, 64'd0, 64'd0, 64'd0);
        #1;
        chk("pre_rst_op", 64'(bus.op), 64'(JAL_P));
        reset = 1'b0;
        #1;
        chk("arst_op", 64'(bus.op), 64'(MAINTAIN));
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_br", 64'(bus.br_cnt), 64'd0);
        chk("arst_tk", 64'(bus.taken_cnt), 64'd0);
        chk("arst_off", bus.offset, 64'd0);
        chk("arst_spc", bus.stall_pc, 64'd0);
        #1;
        reset = 1'b1;
        bus.fetch_ready = 1'b1;
        #1;
        chk("post_rst_op", 64'(bus.op), 64'(PLUS4));
        step();
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
